// File: rtl/mem_lsu_if.sv
// Byte-serial req/ack memory port between the MEM-stage LSU (master) and memory (slave).
interface mem_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ack;

  modport master (output req, output we, output addr, output wdata, input rdata, input ack);
  modport slave  (input req, input we, input addr, input wdata, output rdata, output ack);
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: byte-serial little-endian accesses plus the MEM/WB register.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of running them.
module mem_lsu #(
  parameter int              OP_W       = 8,
  parameter int              REG_ADDR_W = 5,
  parameter logic [OP_W-1:0] ME_NOP_OP  = OP_W'(8'h00),
  parameter logic [OP_W-1:0] EX_LB_OP   = OP_W'(8'h10),
  parameter logic [OP_W-1:0] EX_LH_OP   = OP_W'(8'h11),
  parameter logic [OP_W-1:0] EX_LW_OP   = OP_W'(8'h12),
  parameter logic [OP_W-1:0] EX_LBU_OP  = OP_W'(8'h13),
  parameter logic [OP_W-1:0] EX_LHU_OP  = OP_W'(8'h14),
  parameter logic [OP_W-1:0] EX_SB_OP   = OP_W'(8'h18),
  parameter logic [OP_W-1:0] EX_SH_OP   = OP_W'(8'h19),
  parameter logic [OP_W-1:0] EX_SW_OP   = OP_W'(8'h1A)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_W-1:0]       aluop_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           w_data_i,
  input  logic                  w_enable_i,
  input  logic [REG_ADDR_W-1:0] w_addr_i,
  output logic                  stall_req_o,
  mem_lsu_if.master             mem,
  output logic                  w_enable_o,
  output logic [REG_ADDR_W-1:0] w_addr_o,
  output logic [31:0]           w_data_o,
  output logic                  misalign_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, nxt;

  function automatic logic [2:0] beat_count(input logic [OP_W-1:0] op);
    case (op)
      EX_LB_OP, EX_LBU_OP, EX_SB_OP: beat_count = 3'd1;
      EX_LH_OP, EX_LHU_OP, EX_SH_OP: beat_count = 3'd2;
      EX_LW_OP, EX_SW_OP:            beat_count = 3'd4;
      default:                       beat_count = 3'd0;
    endcase
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    is_store = (op == EX_SB_OP) || (op == EX_SH_OP) || (op == EX_SW_OP);
  endfunction

  function automatic logic [31:0] load_extend(input logic [OP_W-1:0] op, input logic [31:0] b);
    case (op)
      EX_LB_OP:  load_extend = {{24{b[7]}}, b[7:0]};
      EX_LBU_OP: load_extend = {24'h0, b[7:0]};
      EX_LH_OP:  load_extend = {{16{b[15]}}, b[15:0]};
      EX_LHU_OP: load_extend = {16'h0, b[15:0]};
      default:   load_extend = b;
    endcase
  endfunction

  logic                  mem_op_in;
  logic                  trap_in;
  logic                  last_beat;
  logic [OP_W-1:0]       op_p0;
  logic [31:0]           addr_p0;
  logic [31:0]           sdata_p0;
  logic [31:0]           buf_p0;
  logic [REG_ADDR_W-1:0] dest_p0;
  logic                  wen_p0;
  logic [1:0]            beat_p0;

  assign mem_op_in = (beat_count(aluop_i) != 3'd0);
  assign last_beat = ({1'b0, beat_p0} == (beat_count(op_p0) - 3'd1));

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] a);
    case (beat_count(op))
      3'd2:    is_misaligned = a[0];
      3'd4:    is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction
  assign trap_in = is_misaligned(aluop_i, mem_addr_i[1:0]);
`else
  assign trap_in = 1'b0;
`endif

  // Beat address wraps naturally at 2^32; outputs idle at zero outside ACCESS.
  assign mem.addr  = (state == ACCESS) ? (addr_p0 + {30'h0, beat_p0}) : 32'h0;
  assign mem.we    = (state == ACCESS) && is_store(op_p0);
  assign mem.wdata = (state == ACCESS) ? sdata_p0[{beat_p0, 3'b000} +: 8] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt         = state;
    stall_req_o = 1'b0;
    mem.req     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op_in) begin
          stall_req_o = 1'b1;
          nxt         = trap_in ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        mem.req     = 1'b1;
        stall_req_o = 1'b1;
        if (mem.ack && last_beat) nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // p0: transaction latch and load assembly; MEM/WB register follows
  always_ff @(posedge clk) begin
    if (rst) begin
      op_p0      <= ME_NOP_OP;
      addr_p0    <= 32'h0;
      sdata_p0   <= 32'h0;
      buf_p0     <= 32'h0;
      dest_p0    <= '0;
      wen_p0     <= 1'b0;
      beat_p0    <= 2'd0;
      w_enable_o <= 1'b0;
      w_addr_o   <= '0;
      w_data_o   <= 32'h0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op_in) begin
            op_p0      <= aluop_i;
            addr_p0    <= mem_addr_i;
            sdata_p0   <= w_data_i;
            dest_p0    <= w_addr_i;
            wen_p0     <= w_enable_i;
            beat_p0    <= 2'd0;
            buf_p0     <= 32'h0;
            w_enable_o <= 1'b0;
            misalign_o <= trap_in;
          end else begin
            w_enable_o <= w_enable_i && (w_addr_i != '0);
            w_addr_o   <= w_addr_i;
            w_data_o   <= w_data_i;
          end
        end
        ACCESS: begin
          w_enable_o <= 1'b0;
          if (mem.ack) begin
            buf_p0[{beat_p0, 3'b000} +: 8] <= mem.rdata;
            beat_p0                         <= beat_p0 + 2'd1;
          end
        end
        DONE: begin
          w_addr_o <= dest_p0;
          // misalign_o is high only in a trapped DONE cycle: suppress the load write-back
          if (!is_store(op_p0) && !misalign_o) begin
            w_data_o   <= load_extend(op_p0, buf_p0);
            w_enable_o <= wen_p0 && (dest_p0 != '0);
          end else begin
            w_enable_o <= 1'b0;
          end
        end
        default: w_enable_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: directed cases, reset abort, then randomized op stream vs. reference model.
module tb_mem_lsu;
  localparam logic [7:0] NOP = 8'h00, ADD = 8'h01;
  localparam logic [7:0] LB = 8'h10, LH = 8'h11, LW = 8'h12, LBU = 8'h13, LHU = 8'h14;
  localparam logic [7:0] SB = 8'h18, SH = 8'h19, SW = 8'h1A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop = NOP;
  logic [31:0] maddr = 32'h0;
  logic [31:0] wdata_in = 32'h0;
  logic        wen_in = 1'b0;
  logic [4:0]  waddr_in = 5'd0;
  logic        stall, wen_o, mis;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  always #5 clk = ~clk;

  mem_lsu_if mif();

  mem_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .mem_addr_i (maddr),
    .w_data_i   (wdata_in),
    .w_enable_i (wen_in),
    .w_addr_i   (waddr_in),
    .stall_req_o(stall),
    .mem        (mif),
    .w_enable_o (wen_o),
    .w_addr_o   (waddr_o),
    .w_data_o   (wdata_o),
    .misalign_o (mis)
  );

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  int wait_min = 0;
  int wait_max = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic we; logic [7:0] data; } beat_t;
  typedef struct { logic [4:0] addr; logic [31:0] data; int cyc; } wb_t;
  beat_t exp_beats[$];
  wb_t   exp_wb[$];
  int    exp_mis[$];

  logic [7:0] mem_arr [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    mem_arr[a] = v;
    ref_mem[a] = v;
  endtask

  function automatic int nbeats(input logic [7:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    if (op == LW || op == SW) return 4;
    return 0;
  endfunction

  function automatic bit op_is_store(input logic [7:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Little-endian assembly from the model memory, then numeric sign/zero extension.
  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] a);
    int unsigned u = 0;
    for (int k = 0; k < nbeats(op); k++) u += int'(ref_rd(a + k)) << (8 * k);
    if (op == LB && u >= 128)   u = u - 256;
    if (op == LH && u >= 32768) u = u - 65536;
    return u;
  endfunction

  // Memory slave: random waits per beat, checks each acked beat against the scoreboard.
  initial begin
    int    wcnt = -1;
    beat_t b;
    mif.ack   = 1'b0;
    mif.rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (mif.req === 1'b1) begin
        if (wcnt < 0) wcnt = $urandom_range(wait_max, wait_min);
        if (wcnt == 0) begin
          mif.ack   = 1'b1;
          mif.rdata = mem_rd(mif.addr);
          if (mif.we) mem_arr[mif.addr] = mif.wdata;
          if (exp_beats.size() == 0) begin
            total++;
            $display("FAIL unexpected_beat: addr %h we %b, none expected (cycle %0d)", mif.addr, mif.we, cyc);
          end else begin
            b = exp_beats.pop_front();
            check("beat_addr", mif.addr, b.addr);
            check("beat_we", {31'h0, mif.we}, {31'h0, b.we});
            if (b.we) check("beat_wdata", {24'h0, mif.wdata}, {24'h0, b.data});
          end
          wcnt = -1;
        end else begin
          mif.ack   = 1'b0;
          mif.rdata = 8'($urandom);
          wcnt--;
        end
      end else begin
        mif.ack   = 1'b0;
        mif.rdata = 8'($urandom);
        wcnt      = -1;
      end
    end
  end

  // Write-back and misalign monitor.
  initial begin
    wb_t w;
    forever begin
      @(negedge clk);
      if (wen_o === 1'b1) begin
        if (exp_wb.size() == 0) begin
          total++;
          $display("FAIL unexpected_wb: x%0d <= %h, none expected (cycle %0d)", waddr_o, wdata_o, cyc);
        end else begin
          w = exp_wb.pop_front();
          check("wb_addr", {27'h0, waddr_o}, {27'h0, w.addr});
          check("wb_data", wdata_o, w.data);
          check("wb_cycle", cyc, w.cyc);
        end
      end
      if (mis === 1'b1) begin
        if (exp_mis.size() == 0) begin
          total++;
          $display("FAIL unexpected_misalign: pulse at cycle %0d", cyc);
        end else begin
          check("misalign_cycle", cyc, exp_mis.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic [4:0] dst);
    int          n, ic, sc, exp_sc;
    bit          trap, st;
    logic [31:0] lv;
    wb_t         w;
    beat_t       b;
    @(posedge clk);
    #1;
    aluop = op; maddr = a; wdata_in = d; wen_in = we; waddr_in = dst;
    ic = cyc;
    n = nbeats(op);
    st = op_is_store(op);
    trap = 1'b0;
    lv = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`endif
    if (n == 0) begin
      exp_sc = 0;
      if (we && dst != 5'd0) begin
        w.addr = dst; w.data = d; w.cyc = ic + 1;
        exp_wb.push_back(w);
      end
    end else if (trap) begin
      exp_sc = 1;
      exp_mis.push_back(ic + 1);
    end else begin
      exp_sc = 1 + n * (1 + wait_min);
      for (int k = 0; k < n; k++) begin
        b.addr = a + k; b.we = st; b.data = d[8*k +: 8];
        exp_beats.push_back(b);
        if (st) ref_mem[a + k] = d[8*k +: 8];
      end
      lv = ref_load(op, a);
    end
    sc = 0;
    forever begin
      @(negedge clk);
      if (stall !== 1'b1) break;
      sc++;
      if (sc > 200) break;
    end
    if (sc > 200) begin
      total++;
      $display("FAIL stall_timeout: op %h still stalled after %0d cycles", op, sc);
    end else if (wait_min == wait_max || n == 0 || trap) begin
      check("stall_cycles", sc, exp_sc);
    end
    if (n > 0 && !trap && !st && we && dst != 5'd0) begin
      w.addr = dst; w.data = lv; w.cyc = cyc + 1;
      exp_wb.push_back(w);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    aluop = NOP; wen_in = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [10] = '{NOP, ADD, LB, LH, LW, LBU, LHU, SB, SH, SW};
    logic [31:0] ra;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'h0, mif.req}, 32'h0);
    check("rst_we", {31'h0, mif.we}, 32'h0);
    check("rst_addr", mif.addr, 32'h0);
    check("rst_wdata", {24'h0, mif.wdata}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_wen", {31'h0, wen_o}, 32'h0);
    check("rst_waddr", {27'h0, waddr_o}, 32'h0);
    check("rst_wdata_o", wdata_o, 32'h0);
    check("rst_misalign", {31'h0, mis}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    issue(LW, 32'h100, 32'h0, 1'b1, 5'd5);
    poke(32'h200, 8'h80);
    issue(LB, 32'h200, 32'h0, 1'b1, 5'd6);
    issue(LBU, 32'h200, 32'h0, 1'b1, 5'd6);
    wait_min = 3; wait_max = 3;
    issue(SH, 32'h301, 32'hDEADBEEF, 1'b1, 5'd8);
    wait_min = 0; wait_max = 0;
    poke(32'hFFFFFFFE, 8'hA1); poke(32'hFFFFFFFF, 8'hB2); poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
    issue(LW, 32'hFFFFFFFE, 32'h0, 1'b1, 5'd9);
    issue(ADD, 32'h0, 32'h5, 1'b1, 5'd7);
    issue(LW, 32'h100, 32'h0, 1'b1, 5'd0);

    // Reset during beat 2 of a word load aborts it with no write-back.
    @(posedge clk);
    #1;
    aluop = LW; maddr = 32'h500; wen_in = 1'b1; waddr_in = 5'd4;
    for (int k = 0; k < 4; k++) exp_beats.push_back('{32'h500 + k, 1'b0, 8'h00});
    repeat (3) @(posedge clk);
    #1;
    check("abort_beat2_addr", mif.addr, 32'h502);
    rst = 1'b1; aluop = NOP; wen_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_req", {31'h0, mif.req}, 32'h0);
    check("abort_stall", {31'h0, stall}, 32'h0);
    check("abort_wen", {31'h0, wen_o}, 32'h0);
    exp_beats.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(LH, 32'h101, 32'h0, 1'b1, 5'd3);

    for (int i = 0; i < 300; i++) begin
      wait_min = 0;
      wait_max = ((i / 50) % 2 == 1) ? 2 : 0;
      ra = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC + $urandom_range(0, 3))
                                       : (32'h1000 + $urandom_range(0, 31));
      issue(ops[$urandom_range(0, 9)], ra, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end

    idle();
    repeat (4) @(negedge clk);
    check("wb_pending", exp_wb.size(), 0);
    check("beats_pending", exp_beats.size(), 0);
    check("misalign_pending", exp_mis.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
